// File: rtl/trig_merge_rr_pkg.sv
// trig_pkg: shared helpers for the trigger-word merger.
//   tag_width  - channel tag width for a given channel count (never below 1)
//   is_pow2    - power-of-two test used by the FIFO depth check
//   params_ok  - legal N_CH / DEPTH combination, checked at elaboration
package trig_pkg;

    localparam int N_CH_MIN  = 2;
    localparam int N_CH_MAX  = 16;
    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 32;

    function automatic int tag_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit params_ok(input int n_ch, input int depth);
        return (n_ch >= N_CH_MIN) && (n_ch <= N_CH_MAX) &&
               (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX) && is_pow2(depth);
    endfunction

endpackage

// File: rtl/trig_merge_rr_if.sv
// trig_merge_rr_if: input trigger streams, merged output stream and
// per-channel status of the trigger merger.
//   in_valid/in_data   per-channel words (channel i at [i*DW +: DW])
//   out_ready          downstream accept
//   out_valid/out_data/out_ch  merged tagged output
//   ch_full/ovf        per-channel FIFO full and sticky drop flags
//   ovf_clr            per-channel clear of ovf
// master: the side that feeds the merger; slave: the merger itself.
interface trig_merge_rr_if #(
    parameter int N_CH  = 8,
    parameter int DW    = 16,
    parameter int TAG_W = $clog2(N_CH)
);
    logic [N_CH-1:0]    in_valid;
    logic [N_CH*DW-1:0] in_data;
    logic               out_ready;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic [TAG_W-1:0]   out_ch;
    logic [N_CH-1:0]    ch_full;
    logic [N_CH-1:0]    ovf;
    logic [N_CH-1:0]    ovf_clr;

    modport master (
        output in_valid, in_data, out_ready, ovf_clr,
        input  out_valid, out_data, out_ch, ch_full, ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready, ovf_clr,
        output out_valid, out_data, out_ch, ch_full, ovf
    );
endinterface

// File: rtl/trig_merge_rr_ch_fifo.sv
// trig_ch_fifo: single-channel synchronous FIFO for one trigger link.
//   clk/srst   clock, synchronous active-high reset
//   push/push_data  write request (ignored when full unless popped this cycle)
//   pop/pop_data    read request and current head word
//   count/full/empty  registered occupancy
// A push while full is accepted when the same cycle pops, leaving the count
// unchanged. The head is read asynchronously so the arbiter can load it into
// the output register in the same cycle it grants.
module trig_ch_fifo #(
    parameter int  DW    = 16,
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    assign pop_data = mem[rd_ptr_reg];
    assign count    = count_reg;

endmodule

// File: rtl/trig_merge_rr.sv
// trig_merge_rr: N_CH-channel trigger-word merger. Each input link feeds its
// own FIFO; a round-robin arbiter drains the FIFOs into a single registered,
// channel-tagged output stream. Drops on a full channel set a sticky ovf bit
// and never stall the other channels.
//   bclk/rst   clock, synchronous active-high reset
//   bus        trig_merge_rr_if slave: inputs, merged output, ch_full, ovf, ovf_clr
module trig_merge_rr
    import trig_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int TAG_W = tag_width(N_CH)
) (
    input  logic           bclk,
    input  logic           rst,
    trig_merge_rr_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    if (!params_ok(N_CH, DEPTH)) begin : g_bad_params
        $error("trig_merge_rr: N_CH must be 2..16 and DEPTH a power of two in 2..32");
    end
    if (TAG_W < tag_width(N_CH)) begin : g_bad_tag
        $error("trig_merge_rr: TAG_W too narrow for N_CH");
    end

    logic [N_CH-1:0]  fifo_empty;
    logic [N_CH-1:0]  fifo_full;
    logic [N_CH-1:0]  fifo_pop;
    logic [N_CH-1:0]  drop;
    logic [DW-1:0]    fifo_head  [N_CH];
    logic [CW-1:0]    fifo_count [N_CH];

    logic [N_CH-1:0]  ovf_reg;
    logic [N_CH-1:0]  ovf_next;
    logic             out_valid_reg;
    logic [DW-1:0]    out_data_reg;
    logic [TAG_W-1:0] out_ch_reg;
    logic [TAG_W-1:0] last_grant_reg;

    logic             stage_free;
    logic             grant_valid;
    logic [TAG_W-1:0] grant_idx;

    assign stage_free = !out_valid_reg || bus.out_ready;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        trig_ch_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (bclk),
            .srst      (rst),
            .push      (bus.in_valid[gi]),
            .push_data (bus.in_data[gi*DW +: DW]),
            .pop       (fifo_pop[gi]),
            .pop_data  (fifo_head[gi]),
            .count     (fifo_count[gi]),
            .full      (fifo_full[gi]),
            .empty     (fifo_empty[gi])
        );

        assign fifo_pop[gi] = grant_valid && (grant_idx == TAG_W'(gi));

        // A word is lost only when the channel is full and not draining now.
        assign drop[gi] = bus.in_valid[gi] &&
                          (fifo_count[gi] == CW'(DEPTH)) && !fifo_pop[gi];

        // Set dominates clear so a drop in the clearing cycle is not lost.
        assign ovf_next[gi] = (ovf_reg[gi] && !bus.ovf_clr[gi]) || drop[gi];
    end

    // Round-robin: first non-empty channel strictly after the last grant,
    // wrapping; only granted when the output register can take a word.
    always_comb begin
        int cand;
        cand        = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = (int'(last_grant_reg) + k) % N_CH;
            if (!grant_valid && !fifo_empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = TAG_W'(cand);
            end
        end
        if (!stage_free) begin
            grant_valid = 1'b0;
        end
    end

    always_ff @(posedge bclk) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_ch_reg     <= '0;
            last_grant_reg <= TAG_W'(N_CH - 1);
            ovf_reg        <= '0;
        end else begin
            ovf_reg <= ovf_next;
            if (stage_free) begin
                out_valid_reg <= grant_valid;
                if (grant_valid) begin
                    out_data_reg   <= fifo_head[grant_idx];
                    out_ch_reg     <= grant_idx;
                    last_grant_reg <= grant_idx;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_ch    = out_ch_reg;
    assign bus.ch_full   = fifo_full;
    assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_trig_merge_rr.sv
// tb_trig_merge_rr: directed scenarios plus randomized traffic against a
// queue-based reference of the merger. Prints one line per failed comparison
// and a single summary line.
module tb_trig_merge_rr;
    localparam int N_CH  = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int TAG_W = 3;

    logic bclk = 1'b0;
    logic rst  = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    trig_merge_rr_if #(.N_CH(N_CH), .DW(DW), .TAG_W(TAG_W)) bus ();

    trig_merge_rr #(
        .N_CH  (N_CH),
        .DW    (DW),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .bclk (bclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 bclk = ~bclk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model state for the random test
    logic [DW-1:0]   mq [N_CH][$];
    logic            m_valid;
    logic [DW-1:0]   m_data;
    int              m_ch;
    int              m_last;
    logic [N_CH-1:0] m_ovf;
    int              waits [N_CH];

    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = '0;
        bus.in_data  = '0;
        bus.ovf_clr  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push1(input int ch, input logic [DW-1:0] w);
        bus.in_valid = '0;
        bus.in_valid[ch] = 1'b1;
        bus.in_data[ch*DW +: DW] = w;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== '0 || bus.out_ch !== '0) begin
            failures++; $display("FAIL reset_out_data got=%h/%0d want=0/0", bus.out_data, bus.out_ch);
        end
        checks++;
        if (bus.ch_full !== '0 || bus.ovf !== '0) begin
            failures++; $display("FAIL reset_flags got full=%b ovf=%b want=0/0", bus.ch_full, bus.ovf);
        end
    endtask

    task automatic test_latency();
        do_reset();
        push1(3, 16'hA001);
        tick();
        idle_inputs();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL latency_c1 out_valid got=%b want=0", bus.out_valid);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hA001 || bus.out_ch !== 3'd3) begin
            failures++;
            $display("FAIL latency_c2 got v=%b d=%h ch=%0d want v=1 d=a001 ch=3",
                     bus.out_valid, bus.out_data, bus.out_ch);
        end
        // stall with A001 pending and overflow ch1, then reset mid-stream
        bus.out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            push1(1, DW'(16'h1100 + j));
            tick();
        end
        idle_inputs();
        checks++;
        if (bus.ovf[1] !== 1'b1) begin
            failures++; $display("FAIL midrst_pre_ovf got=%b want=1", bus.ovf[1]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ovf !== '0 || bus.ch_full !== '0) begin
            failures++;
            $display("FAIL midrst_state got v=%b ovf=%b full=%b want 0/0/0",
                     bus.out_valid, bus.ovf, bus.ch_full);
        end
        bus.out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++; $display("FAIL midrst_flush cyc=%0d out_valid got=%b want=0", j, bus.out_valid);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < N_CH; i++) begin
                bus.in_valid[i] = 1'b1;
                bus.in_data[i*DW +: DW] = DW'(i << 8);
            end
            tick();
            idle_inputs();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++; $display("FAIL rr_pre rep=%0d out_valid got=%b want=0", rep, bus.out_valid);
            end
            for (int k = 0; k < N_CH; k++) begin
                tick();
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_ch !== TAG_W'(k) || bus.out_data !== DW'(k << 8)) begin
                    failures++;
                    $display("FAIL rr rep=%0d slot=%0d got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                             rep, k, bus.out_valid, bus.out_ch, bus.out_data, k, DW'(k << 8));
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] w0;
        logic [DW-1:0] w [6];
        do_reset();
        bus.out_ready = 1'b0;
        w0 = DW'($urandom());
        for (int j = 0; j < 6; j++) w[j] = DW'($urandom());
        push1(0, w0);
        tick();
        idle_inputs();
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 3'd0 || bus.out_data !== w0) begin
            failures++; $display("FAIL ovf_pending got v=%b ch=%0d d=%h want v=1 ch=0 d=%h",
                                 bus.out_valid, bus.out_ch, bus.out_data, w0);
        end
        for (int j = 0; j < 6; j++) begin
            push1(5, w[j]);
            tick();
            checks++;
            if (bus.ch_full[5] !== (j >= 3) || bus.ovf[5] !== (j >= 4)) begin
                failures++; $display("FAIL ovf_fill word=%0d got full=%b ovf=%b want full=%b ovf=%b",
                                     j + 1, bus.ch_full[5], bus.ovf[5], j >= 3, j >= 4);
            end
        end
        idle_inputs();
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_ch !== 3'd5 || bus.out_data !== w[j]) begin
                failures++; $display("FAIL ovf_drain idx=%0d got v=%b ch=%0d d=%h want v=1 ch=5 d=%h",
                                     j, bus.out_valid, bus.out_ch, bus.out_data, w[j]);
            end
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ch_full[5] !== 1'b0 || bus.ovf[5] !== 1'b1) begin
            failures++; $display("FAIL ovf_after got v=%b full=%b ovf=%b want 0/0/1",
                                 bus.out_valid, bus.ch_full[5], bus.ovf[5]);
        end
        bus.ovf_clr[5] = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (bus.ovf[5] !== 1'b0) begin
            failures++; $display("FAIL ovf_clr got=%b want=0", bus.ovf[5]);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] x;
        logic [DW-1:0] y [4];
        do_reset();
        bus.out_ready = 1'b0;
        x = DW'($urandom());
        for (int j = 0; j < 4; j++) y[j] = DW'($urandom());
        push1(6, x);
        tick();
        for (int j = 0; j < 4; j++) begin
            push1(6, y[j]);
            tick();
        end
        idle_inputs();
        for (int j = 0; j < 10; j++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== x || bus.out_ch !== 3'd6 || bus.ch_full[6] !== 1'b1) begin
                failures++; $display("FAIL stall cyc=%0d got v=%b d=%h ch=%0d full=%b want v=1 d=%h ch=6 full=1",
                                     j, bus.out_valid, bus.out_data, bus.out_ch, bus.ch_full[6], x);
            end
        end
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== y[j]) begin
                failures++; $display("FAIL stall_drain idx=%0d got v=%b d=%h want v=1 d=%h",
                                     j, bus.out_valid, bus.out_data, y[j]);
            end
        end
    endtask

    task automatic test_push_pop_full();
        logic [DW-1:0] p [7];
        do_reset();
        bus.out_ready = 1'b0;
        for (int j = 0; j < 7; j++) p[j] = DW'($urandom());
        for (int j = 0; j < 5; j++) begin
            push1(2, p[j]);
            tick();
        end
        idle_inputs();
        checks++;
        if (bus.ch_full[2] !== 1'b1 || bus.ovf[2] !== 1'b0) begin
            failures++; $display("FAIL ppf_fill got full=%b ovf=%b want 1/0", bus.ch_full[2], bus.ovf[2]);
        end
        bus.out_ready = 1'b1;
        push1(2, p[5]);
        tick();
        idle_inputs();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_data !== p[1] || bus.ch_full[2] !== 1'b1 || bus.ovf[2] !== 1'b0) begin
            failures++; $display("FAIL ppf_same_cycle got d=%h full=%b ovf=%b want d=%h full=1 ovf=0",
                                 bus.out_data, bus.ch_full[2], bus.ovf[2], p[1]);
        end
        push1(2, p[6]);
        bus.ovf_clr[2] = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (bus.ovf[2] !== 1'b1) begin
            failures++; $display("FAIL ppf_set_wins got ovf=%b want=1", bus.ovf[2]);
        end
        bus.out_ready = 1'b1;
        for (int j = 2; j < 6; j++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_ch !== 3'd2 || bus.out_data !== p[j]) begin
                failures++; $display("FAIL ppf_drain idx=%0d got v=%b ch=%0d d=%h want v=1 ch=2 d=%h",
                                     j, bus.out_valid, bus.out_ch, bus.out_data, p[j]);
            end
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL ppf_empty got v=%b want=0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        int dens_tab [5] = '{10, 30, 60, 90, 20};
        int rdy_tab  [5] = '{90, 50, 30, 100, 70};
        logic [N_CH-1:0]    vin;
        logic [N_CH*DW-1:0] din;
        logic [N_CH-1:0]    clr;
        logic [N_CH-1:0]    pend;
        logic [N_CH-1:0]    exp_full;
        logic               rdy;
        logic               free;
        logic               prev_free;
        int                 g;
        int                 c;
        int                 dens;
        int                 rprob;
        do_reset();
        for (int i = 0; i < N_CH; i++) begin
            mq[i].delete();
            waits[i] = 0;
        end
        m_valid = 1'b0; m_data = '0; m_ch = 0; m_last = N_CH - 1; m_ovf = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            dens  = (cyc >= 2900) ? 0 : dens_tab[(cyc / 580) % 5];
            rprob = (cyc >= 2900) ? 100 : rdy_tab[(cyc / 580) % 5];
            for (int i = 0; i < N_CH; i++) begin
                vin[i] = ($urandom_range(99) < dens);
                din[i*DW +: DW] = DW'($urandom());
                clr[i] = ($urandom_range(99) < 3);
            end
            rdy = ($urandom_range(99) < rprob);
            bus.in_valid = vin; bus.in_data = din; bus.ovf_clr = clr; bus.out_ready = rdy;

            // reference: pop by round-robin, then pushes into bounded queues
            for (int i = 0; i < N_CH; i++) pend[i] = (mq[i].size() > 0);
            free = !m_valid || rdy;
            g = -1;
            if (free) begin
                for (int k = 1; k <= N_CH; k++) begin
                    c = (m_last + k) % N_CH;
                    if (g < 0 && mq[c].size() > 0) g = c;
                end
                if (g >= 0) begin
                    m_data = mq[g].pop_front(); m_ch = g; m_last = g; m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int i = 0; i < N_CH; i++) begin
                m_ovf[i] = m_ovf[i] && !clr[i];
                if (vin[i]) begin
                    if (mq[i].size() < DEPTH) mq[i].push_back(din[i*DW +: DW]);
                    else m_ovf[i] = 1'b1;
                end
                exp_full[i] = (mq[i].size() == DEPTH);
            end

            prev_free = free;
            tick();

            checks++;
            if (bus.out_valid !== m_valid) begin
                failures++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, bus.out_valid, m_valid);
            end
            if (m_valid) begin
                checks++;
                if (bus.out_data !== m_data || bus.out_ch !== TAG_W'(m_ch)) begin
                    failures++; $display("FAIL rnd_word cyc=%0d got d=%h ch=%0d want d=%h ch=%0d",
                                         cyc, bus.out_data, bus.out_ch, m_data, m_ch);
                end
            end
            checks++;
            if (bus.ovf !== m_ovf || bus.ch_full !== exp_full) begin
                failures++; $display("FAIL rnd_flags cyc=%0d got ovf=%b full=%b want ovf=%b full=%b",
                                     cyc, bus.ovf, bus.ch_full, m_ovf, exp_full);
            end
            // starvation bound measured on the grants the DUT actually makes
            if (prev_free && bus.out_valid === 1'b1) begin
                checks++;
                for (int i = 0; i < N_CH; i++) begin
                    if (TAG_W'(i) == bus.out_ch) waits[i] = 0;
                    else if (pend[i]) waits[i]++;
                    else waits[i] = 0;
                end
                c = 0;
                for (int i = 0; i < N_CH; i++) if (waits[i] >= N_CH) c = i + 1;
                if (c != 0) begin
                    failures++; $display("FAIL rnd_starve cyc=%0d ch=%0d waited=%0d grants limit=%0d",
                                         cyc, c - 1, waits[c - 1], N_CH - 1);
                end
            end
        end
        c = 0;
        for (int i = 0; i < N_CH; i++) c += mq[i].size();
        checks++;
        if (c != 0 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL rnd_drain left=%0d out_valid=%b want 0/0", c, bus.out_valid);
        end
    endtask

    initial begin
        idle_inputs();
        bus.out_ready = 1'b1;
        test_reset();
        test_latency();
        test_round_robin();
        test_overflow();
        test_stall();
        test_push_pop_full();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
